// File: rtl/clock_pkg.sv
// Shared types for the time-of-day counter.
//   bcd_t   : one BCD digit, always 0-9 on every output
//   field_e : which field a set-mode increment edits
package clock_pkg;
    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        F_SEC = 2'd0,   // clear seconds to 00
        F_MIN = 2'd1,   // minutes +1 mod 60, no carry
        F_HR  = 2'd2,   // hours +1 within range, no carry
        F_RSV = 2'd3    // no effect
    } field_e;
endpackage

// File: rtl/bcd_pair_counter.sv
// Two-digit BCD counter wrapping HI -> LO.
//   clk, reset_n : clock, async active-low reset (loads RST)
//   en           : count one step; carry_out fires when wrapping
//   inc          : count one step without carry (set mode)
//   clr          : load LO (highest priority after reset)
//   carry_out    : combinational, en && value==HI
//   tens, ones   : BCD digits
module bcd_pair_counter
    import clock_pkg::*;
#(
    parameter int LO  = 0,
    parameter int HI  = 59,
    parameter int RST = LO
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic       inc,
    input  logic       clr,
    output logic       carry_out,
    output logic [3:0] tens,
    output logic [3:0] ones
);
    localparam bcd_t LO_T  = bcd_t'(LO / 10);
    localparam bcd_t LO_O  = bcd_t'(LO % 10);
    localparam bcd_t HI_T  = bcd_t'(HI / 10);
    localparam bcd_t HI_O  = bcd_t'(HI % 10);
    localparam bcd_t RST_T = bcd_t'(RST / 10);
    localparam bcd_t RST_O = bcd_t'(RST % 10);

    // Limit is compared on the full pair, so e.g. 23 wraps but 19 rolls to 20.
    logic at_hi;
    assign at_hi     = (tens == HI_T) && (ones == HI_O);
    assign carry_out = en && at_hi;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tens <= RST_T;
            ones <= RST_O;
        end else if (clr) begin
            tens <= LO_T;
            ones <= LO_O;
        end else if (en || inc) begin
            if (at_hi) begin
                tens <= LO_T;
                ones <= LO_O;
            end else if (ones == 4'd9) begin
                ones <= 4'd0;
                tens <= tens + 4'd1;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end
endmodule

// File: rtl/bcd_time_counter.sv
// Time-of-day source: 1 Hz prescaler feeding chained BCD sec/min/hr counters,
// 12/24 h modes, and button-driven time set.
//   clk, reset_n        : clock, async active-low reset
//   run                 : 1 = prescaler and time advance
//   set_en              : 1 = set mode, ticks suppressed, inc edges accepted
//   set_field           : 0 sec (clear), 1 min, 2 hr, 3 none
//   inc                 : debounced button level, rising edge = one step
//   hr_t..sc_o          : BCD digits HH:MM:SS
//   pm                  : PM flag in 12 h mode, 0 in 24 h mode
//   sec_pulse           : high the cycle new time first shows
module bcd_time_counter
    import clock_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter bit MODE_24H = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    input  logic       set_en,
    input  logic [1:0] set_field,
    input  logic       inc,
    output logic [3:0] hr_t,
    output logic [3:0] hr_o,
    output logic [3:0] mn_t,
    output logic [3:0] mn_o,
    output logic [3:0] sc_t,
    output logic [3:0] sc_o,
    output logic       pm,
    output logic       sec_pulse
);
    localparam int             CW = $clog2(CLK_HZ);
    localparam logic [CW-1:0]  TC = CW'(CLK_HZ - 1);

    localparam int HR_LO  = MODE_24H ? 0  : 1;
    localparam int HR_HI  = MODE_24H ? 23 : 12;
    localparam int HR_RST = MODE_24H ? 0  : 12;

    logic [CW-1:0] pre_cnt;
    logic          tick;
    logic          inc_q;
    logic          inc_edge;
    field_e        fld;
    logic          sc_carry, mn_carry, hr_carry_unused;
    logic          mn_inc, hr_inc, sc_clr, hr_step;
    logic          pm_q;

    // Prescaler is held at 0 during set mode so the first tick after leaving
    // set mode lands a full CLK_HZ cycles later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)          pre_cnt <= '0;
        else if (set_en)       pre_cnt <= '0;
        else if (run)          pre_cnt <= (pre_cnt == TC) ? '0 : pre_cnt + 1'b1;
    end

    assign tick = (pre_cnt == TC) && run && !set_en;

    // inc_q tracks inc even outside set mode, so a button already held when
    // set_en rises does not register as an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) inc_q <= 1'b0;
        else          inc_q <= inc;
    end

    assign inc_edge = inc && !inc_q && set_en;
    assign fld      = field_e'(set_field);
    assign sc_clr   = inc_edge && (fld == F_SEC);
    assign mn_inc   = inc_edge && (fld == F_MIN);
    assign hr_inc   = inc_edge && (fld == F_HR);

    bcd_pair_counter #(.LO(0), .HI(59), .RST(0)) u_sec (
        .clk(clk), .reset_n(reset_n), .en(tick), .inc(1'b0), .clr(sc_clr),
        .carry_out(sc_carry), .tens(sc_t), .ones(sc_o)
    );

    bcd_pair_counter #(.LO(0), .HI(59), .RST(0)) u_min (
        .clk(clk), .reset_n(reset_n), .en(sc_carry), .inc(mn_inc), .clr(1'b0),
        .carry_out(mn_carry), .tens(mn_t), .ones(mn_o)
    );

    bcd_pair_counter #(.LO(HR_LO), .HI(HR_HI), .RST(HR_RST)) u_hr (
        .clk(clk), .reset_n(reset_n), .en(mn_carry), .inc(hr_inc), .clr(1'b0),
        .carry_out(hr_carry_unused), .tens(hr_t), .ones(hr_o)
    );

    // pm flips only on 11 -> 12, whether by carry or by set-mode increment.
    assign hr_step = mn_carry || hr_inc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            pm_q <= 1'b0;
        else if (!MODE_24H && hr_step && (hr_t == 4'd1) && (hr_o == 4'd1))
            pm_q <= !pm_q;
    end

    assign pm = pm_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sec_pulse <= 1'b0;
        else          sec_pulse <= tick;
    end
endmodule
